// File: rtl/waveform_analyzer_if.sv
// Sample stream into the analyzer and per-window measurement results out of it.
`timescale 1ns/1ps
interface waveform_analyzer_if;
    logic        sample_valid;
    logic [11:0] sample;
    logic [11:0] maximum;
    logic [11:0] minimum;
    logic [11:0] amplitude;
    logic [15:0] period;
    logic        result_valid;

    modport master (
        output sample_valid, sample,
        input  maximum, minimum, amplitude, period, result_valid
    );

    modport slave (
        input  sample_valid, sample,
        output maximum, minimum, amplitude, period, result_valid
    );
endinterface

// File: rtl/waveform_analyzer.sv
// Per-window max/min/amplitude and hysteretic rising-crossing period of a 12-bit sample stream.
// Results register on the final window sample's edge; no backpressure, every valid sample is consumed.
`timescale 1ns/1ps
module waveform_analyzer #(
    parameter int WINDOW = 1024,
    parameter int HYST   = 8
) (
    input  logic            clock,
    input  logic            resetn,
    waveform_analyzer_if.slave bus
);
    localparam int CW = $clog2(WINDOW);

    typedef enum logic {BELOW, ABOVE} cross_t;

    cross_t        state;
    logic [CW-1:0] wcnt;
    logic [11:0]   run_max;
    logic [11:0]   run_min;
    logic [12:0]   mid;
    logic [15:0]   icnt;
    logic [15:0]   cap_period;
    logic          seen_rise;
    logic          got_period;

    logic [11:0] smp;
    logic [13:0] hi_sum;
    logic [11:0] hi_th;
    logic [11:0] lo_th;
    logic        rising;
    logic        falling;
    logic        capture;
    logic        got_next;
    logic [15:0] per_next;
    logic [11:0] new_max;
    logic [11:0] new_min;
    logic [12:0] sum13;
    logic        last;

    assign smp = bus.sample;

    always_comb begin
        hi_sum   = {1'b0, mid} + 14'(HYST);
        hi_th    = (hi_sum > 14'd4095) ? 12'hFFF : hi_sum[11:0];
        lo_th    = (mid < 13'(HYST)) ? 12'd0 : (mid[11:0] - 12'(HYST));
        rising   = bus.sample_valid && (state == BELOW) && (smp >= hi_th);
        falling  = bus.sample_valid && (state == ABOVE) && (smp <= lo_th);
        // The first rising edge after reset only arms the interval measurement.
        capture  = rising && seen_rise;
        got_next = got_period | capture;
        per_next = capture ? icnt : cap_period;
        new_max  = (smp > run_max) ? smp : run_max;
        new_min  = (smp < run_min) ? smp : run_min;
        sum13    = {1'b0, new_max} + {1'b0, new_min};
        last     = (wcnt == CW'(WINDOW - 1));
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state            <= BELOW;
            wcnt             <= '0;
            run_max          <= 12'd0;
            run_min          <= 12'hFFF;
            mid              <= 13'd2048;
            icnt             <= 16'd0;
            cap_period       <= 16'd0;
            seen_rise        <= 1'b0;
            got_period       <= 1'b0;
            bus.maximum      <= 12'd0;
            bus.minimum      <= 12'd0;
            bus.amplitude    <= 12'd0;
            bus.period       <= 16'd0;
            bus.result_valid <= 1'b0;
        end else begin
            bus.result_valid <= 1'b0;
            if (bus.sample_valid) begin
                wcnt       <= last ? '0 : wcnt + CW'(1);
                cap_period <= per_next;
                if (rising) begin
                    state     <= ABOVE;
                    seen_rise <= 1'b1;
                    icnt      <= 16'd1;
                end else begin
                    if (falling)
                        state <= BELOW;
                    if (icnt != 16'hFFFF)
                        icnt <= icnt + 16'd1;
                end
                if (last) begin
                    bus.maximum      <= new_max;
                    bus.minimum      <= new_min;
                    bus.amplitude    <= new_max - new_min;
                    bus.period       <= got_next ? per_next : 16'd0;
                    bus.result_valid <= 1'b1;
                    // Thresholds for the next window derive from this window's extremes.
                    mid              <= sum13 >> 1;
                    run_max          <= 12'd0;
                    run_min          <= 12'hFFF;
                    got_period       <= 1'b0;
                end else begin
                    run_max    <= new_max;
                    run_min    <= new_min;
                    got_period <= got_next;
                end
            end
        end
    end
endmodule

// File: tb/tb_waveform_analyzer.sv
// Scoreboard bench: a 1024-sample and a 16-sample analyzer driven in parallel against a window-level model.
`timescale 1ns/1ps
module tb_waveform_analyzer;
    localparam int HY = 8;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic rstn_a = 1'b0;
    logic rstn_b = 1'b0;
    logic rstd_a = 1'b1;
    logic rstd_b = 1'b1;

    waveform_analyzer_if ifa();
    waveform_analyzer_if ifb();

    waveform_analyzer #(.WINDOW(1024), .HYST(HY)) dut_a (.clock(clock), .resetn(rstn_a), .bus(ifa));
    waveform_analyzer #(.WINDOW(16),   .HYST(HY)) dut_b (.clock(clock), .resetn(rstn_b), .bus(ifb));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clock) begin
        cyc    <= cyc + 1;
        rstd_a <= !rstn_a;
        rstd_b <= !rstn_b;
    end

    typedef struct {
        int mx;
        int mn;
        int am;
        int pe;
        int cy;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    // Reference model state, indexed by bench DUT number.
    int     W[2] = '{1024, 16};
    int     m_mid[2], m_hi[2], m_lo[2], m_wcnt[2], m_wmax[2], m_wmin[2], m_per[2];
    bit     m_above[2], m_have[2], m_got[2];
    longint m_n[2], m_last[2];
    logic [52:0] l_out[2];

    task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", nm, d, cyc, act, req);
        end
    endtask

    task automatic model_reset(input int d);
        m_mid[d]   = 2048;
        m_above[d] = 1'b0;
        m_have[d]  = 1'b0;
        m_got[d]   = 1'b0;
        m_per[d]   = 0;
        m_wcnt[d]  = 0;
        m_wmax[d]  = 0;
        m_wmin[d]  = 4095;
        m_n[d]     = 0;
        m_last[d]  = 0;
    endtask

    task automatic model_accept(input int d, input int s);
        exp_t e;
        if (m_wcnt[d] == 0) begin
            m_hi[d] = (m_mid[d] + HY > 4095) ? 4095 : m_mid[d] + HY;
            m_lo[d] = (m_mid[d] - HY < 0) ? 0 : m_mid[d] - HY;
        end
        if (s > m_wmax[d]) m_wmax[d] = s;
        if (s < m_wmin[d]) m_wmin[d] = s;
        if (!m_above[d] && s >= m_hi[d]) begin
            m_above[d] = 1'b1;
            if (m_have[d]) begin
                m_got[d] = 1'b1;
                m_per[d] = (m_n[d] - m_last[d] > 65535) ? 65535 : int'(m_n[d] - m_last[d]);
            end
            m_have[d] = 1'b1;
            m_last[d] = m_n[d];
        end else if (m_above[d] && s <= m_lo[d]) begin
            m_above[d] = 1'b0;
        end
        m_n[d]++;
        m_wcnt[d]++;
        if (m_wcnt[d] == W[d]) begin
            e.mx = m_wmax[d];
            e.mn = m_wmin[d];
            e.am = m_wmax[d] - m_wmin[d];
            e.pe = m_got[d] ? m_per[d] : 0;
            e.cy = cyc + 1;
            if (d == 0) qa.push_back(e); else qb.push_back(e);
            m_mid[d]  = (m_wmax[d] + m_wmin[d]) / 2;
            m_wmax[d] = 0;
            m_wmin[d] = 4095;
            m_got[d]  = 1'b0;
            m_wcnt[d] = 0;
        end
    endtask

    task automatic drive(input int d, input bit v, input int s);
        @(posedge clock);
        #1;
        if (d == 0) begin
            ifa.sample_valid = v;
            ifa.sample       = 12'(s);
        end else begin
            ifb.sample_valid = v;
            ifb.sample       = 12'(s);
        end
        if (v) model_accept(d, s);
    endtask

    task automatic apply_reset(input int d, input int n);
        @(posedge clock);
        #1;
        if (d == 0) begin
            rstn_a = 1'b0;
            ifa.sample_valid = 1'b0;
        end else begin
            rstn_b = 1'b0;
            ifb.sample_valid = 1'b0;
        end
        model_reset(d);
        repeat (n) @(posedge clock);
        #1;
        if (d == 0) rstn_a = 1'b1; else rstn_b = 1'b1;
    endtask

    task automatic mon(input int d, input bit rd, input logic rv, input logic [11:0] mx,
                       input logic [11:0] mn, input logic [11:0] am, input logic [15:0] pe);
        exp_t e;
        if (rd) begin
            chk("reset_outputs", d, 64'({rv, mx, mn, am, pe}), 64'd0);
            l_out[d] = '0;
        end else if (rv === 1'b1) begin
            if ((d == 0 && qa.size() == 0) || (d == 1 && qb.size() == 0)) begin
                chk("unexpected_result_valid", d, 64'd1, 64'd0);
            end else begin
                e = (d == 0) ? qa.pop_front() : qb.pop_front();
                chk("result_cycle", d, 64'(cyc), 64'(e.cy));
                chk("maximum", d, 64'(mx), 64'(e.mx));
                chk("minimum", d, 64'(mn), 64'(e.mn));
                chk("amplitude", d, 64'(am), 64'(e.am));
                chk("period", d, 64'(pe), 64'(e.pe));
            end
            l_out[d] = {1'b0, mx, mn, am, pe};
        end else begin
            chk("hold", d, 64'({rv, mx, mn, am, pe}), 64'(l_out[d]));
        end
    endtask

    always @(negedge clock)
        mon(0, rstd_a, ifa.result_valid, ifa.maximum, ifa.minimum, ifa.amplitude, ifa.period);
    always @(negedge clock)
        mon(1, rstd_b, ifb.result_valid, ifb.maximum, ifb.minimum, ifb.amplitude, ifb.period);

    function automatic int sq(input int i);
        return ((i / 50) % 2 != 0) ? 4000 : 0;
    endfunction

    // Noisy square wave with random levels and half-period, optionally gappy valid.
    task automatic rand_wave(input int d, input int nacc, input int pct);
        int lo, hi, half, noise, k, acc, s;
        lo    = int'($urandom_range(0, 2000));
        hi    = int'($urandom_range(2100, 4095));
        half  = int'($urandom_range(2, 60));
        noise = int'($urandom_range(0, 12));
        k     = 0;
        acc   = 0;
        while (acc < nacc) begin
            if (int'($urandom_range(0, 99)) < pct) begin
                s = (((k / half) % 2) != 0) ? hi : lo;
                s = s + int'($urandom_range(0, 2 * noise)) - noise;
                if (s < 0) s = 0;
                if (s > 4095) s = 4095;
                drive(d, 1'b1, s);
                k++;
                acc++;
            end else begin
                drive(d, 1'b0, int'($urandom_range(0, 4095)));
            end
        end
    endtask

    task automatic seq_a();
        apply_reset(0, 3);
        repeat (1024) drive(0, 1'b1, 1000);
        repeat (5) drive(0, 1'b0, 0);
        apply_reset(0, 3);
        for (int i = 0; i < 2048; i++) drive(0, 1'b1, sq(i));
        repeat (3) drive(0, 1'b0, 0);
        apply_reset(0, 3);
        for (int i = 0; i < 2048; i++) begin
            drive(0, 1'b1, sq(i));
            drive(0, 1'b0, int'($urandom_range(0, 4095)));
        end
        apply_reset(0, 3);
        for (int i = 0; i < 1024; i++) drive(0, 1'b1, (i % 2 != 0) ? 2052 : 2044);
        repeat (4) drive(0, 1'b0, 0);
        apply_reset(0, 3);
        repeat (500) drive(0, 1'b1, int'($urandom_range(0, 4095)));
        apply_reset(0, 3);
        repeat (1024) drive(0, 1'b1, int'($urandom_range(0, 4095)));
        repeat (5) drive(0, 1'b0, 0);
        rand_wave(0, 1400, 70);
        rand_wave(0, 1672, 85);
        repeat (5) drive(0, 1'b0, 0);
    endtask

    task automatic seq_b();
        apply_reset(1, 3);
        // Rising edges land on index 15 of each window.
        for (int i = 0; i < 64; i++) drive(1, 1'b1, (((i + 1) % 16) < 8) ? 4095 : 0);
        repeat (3) drive(1, 1'b0, 0);
        rand_wave(1, 7, 100);
        apply_reset(1, 2);
        rand_wave(1, 160, 60);
        rand_wave(1, 96, 100);
        rand_wave(1, 200, 50);
        for (int i = 0; i < 300; i++) drive(1, 1'b1, int'($urandom_range(0, 4095)));
        repeat (5) drive(1, 1'b0, 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time budget exhausted");
        $fatal(1, "timeout");
    end

    initial begin : main
        ifa.sample_valid = 1'b0;
        ifa.sample       = 12'd0;
        ifb.sample_valid = 1'b0;
        ifb.sample       = 12'd0;
        model_reset(0);
        model_reset(1);
        l_out[0] = '0;
        l_out[1] = '0;
        fork
            seq_a();
            seq_b();
        join
        repeat (5) @(posedge clock);
        chk("pending_results", 0, 64'(qa.size()), 64'd0);
        chk("pending_results", 1, 64'(qb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/waveform_analyzer.md
WAVEFORM_ANALYZER -- requirements
Module: waveform_analyzer

Interface
REQ-001 Parameter WINDOW, default 1024: valid samples per measurement window (power of two, 16..65536).
REQ-002 Parameter HYST, default 8: crossing hysteresis in LSB (0..255).
REQ-003 clock  input  1  sole clock; all logic on rising edge.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 sample_valid  input  1  qualifies sample this cycle.
REQ-006 sample  input  12  unsigned waveform sample (0..4095).
REQ-007 maximum  output  12  largest sample of last completed window.
REQ-008 minimum  output  12  smallest sample of last completed window.
REQ-009 amplitude  output  12  maximum minus minimum of last completed window.
REQ-010 period  output  16  last rising-crossing interval in valid samples captured in last window; 0 if none.
REQ-011 result_valid  output  1  one-cycle pulse when new results are presented.

Function
REQ-012 The block SHALL ignore sample whenever sample_valid=0; no counter, FSM or tracker SHALL advance.
REQ-013 The window counter SHALL count accepted samples 0..WINDOW-1 and wrap to 0 after the sample at WINDOW-1.
REQ-014 Running max/min SHALL start each window at 0/4095 and update on every accepted sample, comparison unsigned.
REQ-015 Threshold mid SHALL be (maximum+minimum)>>1 computed in 13 bits from the latched outputs; it SHALL be 2048 until the first window completes.
REQ-016 hi_th SHALL be min(mid+HYST,4095); lo_th SHALL be max(mid-HYST,0); no wrap-around.
REQ-017 Crossing FSM, states BELOW and ABOVE: BELOW->ABOVE when accepted sample >= hi_th (rising crossing event); ABOVE->BELOW when accepted sample <= lo_th; otherwise hold.
REQ-018 The interval counter SHALL increment per accepted sample, saturate at 65535, and on a rising crossing load 1.
REQ-019 On a rising crossing after at least one earlier rising crossing since reset, captured_period SHALL take the counter value including the crossing sample, saturated to 65535, and a per-window got_period flag SHALL set.
REQ-020 FSM state, interval counter and edge history SHALL persist across window boundaries; only running max/min and got_period SHALL restart.
REQ-021 On the accepted sample at index WINDOW-1, the registered outputs SHALL update on that edge with that sample included in max/min and any crossing on that sample included in period.
REQ-022 period SHALL be captured_period if got_period (including the final sample), else 0.
REQ-023 result_valid SHALL be 1 for exactly the cycle following acceptance of the final window sample; 0 otherwise.
REQ-024 Outputs SHALL hold between window completions.
REQ-025 New thresholds SHALL apply from the first sample of the next window.

Reset
REQ-026 While resetn=0 at a rising edge: maximum, minimum, amplitude, period = 0; result_valid = 0.
REQ-027 Reset SHALL set window counter 0, running max/min 0/4095, FSM BELOW, interval counter 0, edge history clear, got_period 0, mid 2048.
REQ-028 Reset mid-window SHALL discard the partial window; the next result SHALL follow WINDOW accepted samples after release.

Verification
REQ-029 resetn low 3 cycles after 500 accepted samples -> all outputs 0, result_valid 0; next pulse only after 1024 further accepted samples.
REQ-030 Constant 1000, sample_valid=1, 1024 cycles -> single result_valid pulse; maximum=1000, minimum=1000, amplitude=0, period=0.
REQ-031 Square wave 50 samples 0 / 50 samples 4000, continuous valid -> first window maximum=4000, minimum=0, amplitude=4000, period=100; second window mid=2000, same results.
REQ-032 Same square wave with sample_valid every other cycle -> identical results; result_valid every 2048 cycles.
REQ-033 Samples alternating 2044/2052 (within HYST of 2048) -> no crossings; period=0, maximum=2052, minimum=2044.
REQ-034 WINDOW=16, square wave 0/4095 period 16 aligned so a rising crossing falls on index 15 -> that window's period=16, result_valid on following cycle.
